dot_seq: RTL and testbench

Dot-product sequencer directly upstream of the signed 8x8 multiply-accumulate stage. On `start` it reads `len` operand pairs from two synchronous-read memories (`mem_a`, `mem_b`), clears the MAC accumulator, and streams the pairs into the MAC one per cycle. It then waits for the pipeline to drain and captures the 26-bit accumulator into `result` with a one-cycle `done` pulse. This is the control front-end of a neuron/filter datapath.

---
 rtl/dot_seq.sv | 162 ++++++++++++++++
 tb/tb_dot_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_seq.sv
// -----------------------------------------------------------------------------
// dot_seq : dot-product sequencer feeding a signed 8x8 multiply-accumulate.
//
// On start it clears the MAC, reads len operand pairs from two synchronous-read
// memories (one pair per cycle), presents them to the MAC through a registered,
// valid-gated operand stage, waits for the last product to land in the
// accumulator, then captures the accumulator into result and pulses done.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, len        request a dot product of len pairs (len = 0 allowed)
//   busy, done        sequencer active / one-cycle result-valid pulse
//   result            captured 26-bit accumulator, held until the next done
//   addr, rd_en       shared read address and strobe for mem_a / mem_b
//   rdata_a, rdata_b  signed memory data, valid the cycle after rd_en
//   mac_in1, mac_in2  registered signed MAC operands, zero when not valid
//   mac_clr_n         synchronous active-low accumulator clear
//   mac_acc           MAC accumulator
// -----------------------------------------------------------------------------
module dot_seq #(
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W:0]     len,
    output logic                busy,
    output logic                done,
    output logic signed [25:0]  result,
    output logic [ADDR_W-1:0]   addr,
    output logic                rd_en,
    input  logic signed [7:0]   rdata_a,
    input  logic signed [7:0]   rdata_b,
    output logic signed [7:0]   mac_in1,
    output logic signed [7:0]   mac_in2,
    output logic                mac_clr_n,
    input  logic signed [25:0]  mac_acc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W:0]        len_q, len_d;
    logic [ADDR_W:0]        cnt_q, cnt_d;      // pairs issued so far
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rd_en_q, rd_en_d;
    logic                   clr_n_q, clr_n_d;
    logic signed [25:0]     result_q, result_d;

    logic                   vld_p1_q, vld_p1_d; // memory data valid
    logic                   vld_p2_q, vld_p2_d; // MAC operands valid
    logic signed [7:0]      mac_in1_q, mac_in1_d;
    logic signed [7:0]      mac_in2_q, mac_in2_d;

    // Control: the memory-side outputs are registered and decided one cycle
    // ahead, so they line up with the state they belong to.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rd_en_d  = 1'b0;
        clr_n_d  = 1'b1;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        len_d   = len;
                        cnt_d   = {{ADDR_W{1'b0}}, 1'b1};
                        addr_d  = '0;
                        rd_en_d = 1'b1;
                        clr_n_d = 1'b0;
                        state_d = S_CLR;
                    end
                end
            end
            // CLR issues index 0; it and RUN share the issue logic.
            S_CLR, S_RUN: begin
                if (cnt_q == len_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_RUN;
                end
            end
            // Once neither pipeline stage holds a pair, the accumulator
            // already contains the final product.
            S_DRAIN: begin
                if (!vld_p1_q && !vld_p2_q) begin
                    result_d = mac_acc;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: gating with valid keeps the MAC's free-running accumulate
    // from picking up stale memory data.
    always_comb begin
        vld_p1_d  = rd_en_q;
        vld_p2_d  = vld_p1_q;
        mac_in1_d = vld_p1_q ? rdata_a : 8'sd0;
        mac_in2_d = vld_p1_q ? rdata_b : 8'sd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            clr_n_q   <= 1'b1;
            result_q  <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            mac_in1_q <= '0;
            mac_in2_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            clr_n_q   <= clr_n_d;
            result_q  <= result_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            mac_in1_q <= mac_in1_d;
            mac_in2_q <= mac_in2_d;
        end
    end

    assign busy      = (state_q == S_CLR) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign addr      = addr_q;
    assign rd_en     = rd_en_q;
    assign mac_clr_n = clr_n_q;
    assign mac_in1   = mac_in1_q;
    assign mac_in2   = mac_in2_q;

endmodule

// File: tb/tb_dot_seq.sv
// -----------------------------------------------------------------------------
// tb_dot_seq : bench for dot_seq with behavioural memories and MAC, a
// cycle-timing model of the sequencer and directed vectors.
// -----------------------------------------------------------------------------
module tb_dot_seq;

    localparam int AW = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [AW:0]         len = '0;
    logic                busy, done, rd_en, mac_clr_n;
    logic signed [25:0]  result;
    logic [AW-1:0]       addr;
    logic signed [7:0]   rdata_a = '0, rdata_b = '0;
    logic signed [7:0]   mac_in1, mac_in2;
    logic signed [25:0]  mac_acc = '0;

    dot_seq #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .busy(busy), .done(done), .result(result),
        .addr(addr), .rd_en(rd_en),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .mac_in1(mac_in1), .mac_in2(mac_in2),
        .mac_clr_n(mac_clr_n), .mac_acc(mac_acc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: two synchronous-read memories and the MAC.
    logic signed [7:0] mem_a [32];
    logic signed [7:0] mem_b [32];

    always @(posedge clk) begin
        if (rd_en) begin
            rdata_a <= mem_a[addr];
            rdata_b <= mem_b[addr];
        end
    end

    always @(posedge clk) begin
        if (!mac_clr_n) mac_acc <= '0;
        else            mac_acc <= mac_acc + mac_in1 * mac_in2;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a start seen while no operation is outstanding begins one; all
    // expectations follow from the cycle offset d since that start.
    bit                active = 1'b0;
    int                op_start, op_len, d, dc;
    logic signed [7:0] oa [32];
    logic signed [7:0] ob [32];
    logic [25:0]       op_sum, held = '0;
    logic [AW-1:0]     exp_addr = '0;
    logic              e_rd, e_clr, e_busy, e_done;
    logic signed [7:0] e_m1, e_m2;

    always @(negedge clk) begin
        if (!rst_n) begin
            active   = 1'b0;
            held     = '0;
            exp_addr = '0;
            chk("rst_busy",  32'(busy),      32'd0);
            chk("rst_done",  32'(done),      32'd0);
            chk("rst_rd_en", 32'(rd_en),     32'd0);
            chk("rst_clr_n", 32'(mac_clr_n), 32'd1);
            chk("rst_addr",  32'(addr),      32'd0);
            chk("rst_res",   32'(result),    32'd0);
            chk("rst_m1",    32'(mac_in1),   32'd0);
            chk("rst_m2",    32'(mac_in2),   32'd0);
        end else begin
            if (!active && start) begin
                int s;
                active   = 1'b1;
                op_start = cyc;
                op_len   = int'(len);
                s = 0;
                for (int i = 0; i < 32; i++) begin
                    oa[i] = mem_a[i];
                    ob[i] = mem_b[i];
                    if (i < op_len) s += int'(mem_a[i]) * int'(mem_b[i]);
                end
                op_sum = 26'(s);
            end
            e_rd = 1'b0; e_clr = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            e_m1 = '0;   e_m2 = '0;
            d = 0; dc = 0;
            if (active) begin
                d  = cyc - op_start;
                dc = (op_len == 0) ? 1 : op_len + 4;
                if (op_len > 0 && d >= 1 && d <= op_len) begin
                    e_rd     = 1'b1;
                    exp_addr = AW'(d - 1);
                end
                if (op_len > 0 && d == 1) e_clr = 1'b0;
                if (d >= 1 && d < dc)     e_busy = 1'b1;
                if (d == dc) begin
                    e_done = 1'b1;
                    held   = op_sum;
                end
                if (d >= 3 && d - 3 < op_len) begin
                    e_m1 = oa[d-3];
                    e_m2 = ob[d-3];
                end
            end
            chk("busy",   32'(busy),      32'(e_busy));
            chk("done",   32'(done),      32'(e_done));
            chk("rd_en",  32'(rd_en),     32'(e_rd));
            chk("clr_n",  32'(mac_clr_n), 32'(e_clr));
            chk("addr",   32'(addr),      32'(exp_addr));
            chk("mac_in1", 32'(mac_in1),  32'(e_m1));
            chk("mac_in2", 32'(mac_in2),  32'(e_m2));
            chk("result", 32'(result[25:0]), 32'(held));
            if (active && d == dc) active = 1'b0;
        end
    end

    // Driver
    int t0, dcyc;

    task automatic start_op(input int l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = (AW+1)'(l);
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        if (!seen) begin
            dcyc = -1;
            chk("done_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic load_a();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = (i < 4) ? 8'(i + 1) : 8'sd0;
            mem_b[i] = (i < 4) ? 8'(i + 5) : 8'sd0;
        end
    endtask

    initial begin
        load_a();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("init_busy",   32'(busy),   32'd0);
        chk("init_result", 32'(result), 32'd0);

        // Small positive vector
        start_op(4);
        wait_done();
        chk("A_latency", 32'(dcyc - t0), 32'd8);
        chk("A_result",  32'(result),    32'd70);

        // Sign extension at the operand extremes
        mem_a[0] = -8'sd128; mem_a[1] = -8'sd128; mem_a[2] = 8'sd127;
        mem_b[0] = -8'sd128; mem_b[1] = 8'sd127;  mem_b[2] = -8'sd128;
        start_op(3);
        wait_done();
        chk("B_latency", 32'(dcyc - t0), 32'd7);
        chk("B_result",  32'(result[25:0]), 32'h3FFC100);

        // Full-length vector, address must top out at 31
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = -8'sd128;
            mem_b[i] = -8'sd128;
        end
        start_op(32);
        wait_done();
        chk("C_latency", 32'(dcyc - t0), 32'd36);
        chk("C_result",  32'(result),    32'd524288);
        chk("C_addr",    32'(addr),      32'd31);

        // Empty vector
        start_op(0);
        wait_done();
        chk("D_latency", 32'(dcyc - t0), 32'd1);
        chk("D_result",  32'(result),    32'd0);

        // start and len disturbed mid-run, then back-to-back start
        load_a();
        start_op(4);
        @(posedge clk); #1;
        start = 1'b1;
        len   = (AW+1)'(7);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        chk("E_latency", 32'(dcyc - t0), 32'd8);
        chk("E_result",  32'(result),    32'd70);
        start_op(2);
        wait_done();
        chk("E2_latency", 32'(dcyc - t0), 32'd6);
        chk("E2_result",  32'(result),    32'd17);

        // Reset in the middle of a run, then a clean rerun
        start_op(4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("F_busy",  32'(busy),      32'd0);
        chk("F_rd_en", 32'(rd_en),     32'd0);
        chk("F_addr",  32'(addr),      32'd0);
        chk("F_clr_n", 32'(mac_clr_n), 32'd1);
        chk("F_done",  32'(done),      32'd0);
        chk("F_res",   32'(result),    32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start_op(4);
        wait_done();
        chk("F2_latency", 32'(dcyc - t0), 32'd8);
        chk("F2_result",  32'(result),    32'd70);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
